// File: rtl/i2c_pkg.sv
// i2c_pkg: encodings and constants shared by the I2C target register file.
//   i2c_state_t      : protocol state of the target FSM
//   ADV7513_I2C_ADDR : default 7-bit target address (0x72/0x73 on the wire)
//   I2C_ACK          : SDA level that signals acknowledge
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_PTR,
        ST_ACK_PTR,
        ST_WR_BYTE,
        ST_ACK_WR,
        ST_RD_BYTE,
        ST_RD_ACK
    } i2c_state_t;

    localparam logic [6:0] ADV7513_I2C_ADDR = 7'h39;
    localparam logic       I2C_ACK          = 1'b0;

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: two-flop synchroniser for one I2C pad, plus a history flop
// for edge detection in the clk_1us domain.
//   clk_1us : sampling clock
//   reset   : asynchronous, active-low
//   pad_in  : raw pad value
//   level   : synchronised level
//   rise    : one-cycle pulse on a synchronised 0->1 transition
//   fall    : one-cycle pulse on a synchronised 1->0 transition
module i2c_sync_edge (
    input  logic clk_1us,
    input  logic reset,
    input  logic pad_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic       hist_q;

    // Reset to the idle bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk_1us or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], pad_in};
            hist_q <= sync_q[1];
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~hist_q;
    assign fall  = ~sync_q[1] & hist_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target with a small byte-addressed register file.
// Accepts <addr+W><ptr><data...> writes and <addr+W><ptr> Sr <addr+R><data...>
// reads; the pointer auto-increments and is kept across START/STOP.
//   clk_1us   : 1 MHz sampling clock (SCL/SDA are oversampled)
//   reset     : asynchronous, active-low
//   scl_in    : SCL pad value
//   sda_in    : SDA pad value
//   sda_oe    : 1 = pull SDA low
//   busy      : addressed and in a transfer
//   wr_strobe : one-cycle pulse per register write, with wr_addr/wr_data
//   dbg_addr  : side-band read address
//   dbg_data  : reg[dbg_addr], 8'hFF when out of range
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR      = ADV7513_I2C_ADDR,
    parameter int unsigned REG_ADDR_BITS = 4,
    parameter logic [7:0]  REG_INIT      = 8'h00
) (
    input  logic       clk_1us,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       busy,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data
);

    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_BITS;

    logic       scl_lvl, scl_rise, scl_fall;
    logic       sda_lvl, sda_rise, sda_fall;
    logic       bus_start, bus_stop;

    i2c_state_t state;
    logic [7:0] regs [NUM_REGS];
    logic [7:0] ptr;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       rw;

    logic [7:0] shifted;
    logic       last_bit;
    logic [7:0] ptr_inc;
    logic [7:0] rd_cur;
    logic [7:0] rd_next;

    function automatic logic in_range(input logic [7:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    i2c_sync_edge u_scl_sync (
        .clk_1us (clk_1us),
        .reset   (reset),
        .pad_in  (scl_in),
        .level   (scl_lvl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk_1us (clk_1us),
        .reset   (reset),
        .pad_in  (sda_in),
        .level   (sda_lvl),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    assign bus_start = sda_fall & scl_lvl;
    assign bus_stop  = sda_rise & scl_lvl;

    assign shifted  = {shreg[6:0], sda_lvl};
    assign last_bit = (bit_cnt == 3'd7);
    assign ptr_inc  = ptr + 8'd1;

    assign rd_cur   = in_range(ptr)      ? regs[ptr[REG_ADDR_BITS-1:0]]      : 8'hFF;
    assign rd_next  = in_range(ptr_inc)  ? regs[ptr_inc[REG_ADDR_BITS-1:0]]  : 8'hFF;
    assign dbg_data = in_range(dbg_addr) ? regs[dbg_addr[REG_ADDR_BITS-1:0]] : 8'hFF;

    always_ff @(posedge clk_1us or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            ptr       <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            rw        <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= REG_INIT;
            end
        end else begin
            wr_strobe <= 1'b0;
            if (bus_start) begin
                state   <= ST_ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (bus_stop) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: ;

                    ST_ADDR: begin
                        if (scl_rise) begin
                            shreg   <= shifted;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                if (shifted[7:1] == DEV_ADDR) begin
                                    state <= ST_ACK_ADDR;
                                    rw    <= shifted[0];
                                    busy  <= 1'b1;
                                end else begin
                                    state <= ST_IDLE;
                                end
                            end
                        end
                    end

                    // ACK slots span two SCL falls: the first asserts the
                    // pull-down, the second ends the slot. sda_oe itself
                    // marks which half we are in.
                    ST_ACK_ADDR: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                bit_cnt <= '0;
                                if (rw) begin
                                    // First read bit goes out on this same fall.
                                    shreg  <= rd_cur;
                                    sda_oe <= ~rd_cur[7];
                                    state  <= ST_RD_BYTE;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= ST_PTR;
                                end
                            end
                        end
                    end

                    ST_PTR: begin
                        if (scl_rise) begin
                            shreg   <= shifted;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                ptr   <= shifted;
                                state <= ST_ACK_PTR;
                            end
                        end
                    end

                    ST_ACK_PTR, ST_ACK_WR: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= ST_WR_BYTE;
                            end
                        end
                    end

                    ST_WR_BYTE: begin
                        if (scl_rise) begin
                            shreg   <= shifted;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= ptr;
                                wr_data   <= shifted;
                                if (in_range(ptr)) begin
                                    regs[ptr[REG_ADDR_BITS-1:0]] <= shifted;
                                end
                                ptr   <= ptr_inc;
                                state <= ST_ACK_WR;
                            end
                        end
                    end

                    ST_RD_BYTE: begin
                        if (scl_fall) begin
                            sda_oe <= ~shreg[7];
                        end else if (scl_rise) begin
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                state <= ST_RD_ACK;
                            end
                        end
                    end

                    ST_RD_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                        end else if (scl_rise) begin
                            bit_cnt <= '0;
                            if (sda_lvl == I2C_ACK) begin
                                ptr   <= ptr_inc;
                                shreg <= rd_next;
                                state <= ST_RD_BYTE;
                            end else begin
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Self-checking bench for i2c_target_regfile: bit-banged I2C initiator at
// about 83 kHz (6 us low / 6 us high), a register-file reference model,
// a directed vector table, hand-written corner cases and random traffic.
module tb_i2c_target_regfile;

    logic       clk_1us = 1'b0;
    logic       reset   = 1'b0;
    logic       scl     = 1'b1;
    logic       msda    = 1'b1;
    logic       sda_line;
    logic       sda_oe, busy, wr_strobe;
    logic [7:0] wr_addr, wr_data, dbg_addr, dbg_data;

    assign sda_line = msda & ~sda_oe;

    i2c_target_regfile #(
        .DEV_ADDR      (7'h39),
        .REG_ADDR_BITS (4),
        .REG_INIT      (8'h00)
    ) dut (
        .clk_1us   (clk_1us),
        .reset     (reset),
        .scl_in    (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #500 clk_1us = ~clk_1us;

    int n_pass = 0;
    int n_chk  = 0;

    logic [15:0] strobe_q[$];
    logic        oe_seen;
    logic [7:0]  wq[$];

    // Reference model: register contents and the auto-incrementing pointer.
    logic [7:0]  m_regs[16];
    int          m_ptr;

    always @(negedge clk_1us) begin
        if (wr_strobe) strobe_q.push_back({wr_addr, wr_data});
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] model_read(input int a);
        return (a < 16) ? m_regs[a] : 8'hFF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_1us);
    endtask

    // Bus tasks that end with SCL low leave us 3 cycles into the low phase.
    task automatic bus_start_idle();
        msda = 1'b1; cyc(2);
        msda = 1'b0; cyc(5);
        scl  = 1'b0; cyc(3);
    endtask

    task automatic bus_restart();
        msda = 1'b1; cyc(3);
        scl  = 1'b1; cyc(4);
        msda = 1'b0; cyc(5);
        scl  = 1'b0; cyc(3);
    endtask

    task automatic bus_stop();
        msda = 1'b0; cyc(3);
        scl  = 1'b1; cyc(4);
        msda = 1'b1; cyc(6);
    endtask

    task automatic clk_bit(input logic b, output logic s, output logic oe);
        msda = b;    cyc(3);
        scl  = 1'b1; cyc(3);
        s  = sda_line;
        oe = sda_oe;
        cyc(3);
        scl  = 1'b0; cyc(3);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic s, o;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s, o);
        clk_bit(1'b1, s, o);
        acked = ~s;
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] d, output logic oe_ack);
        logic s, o;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, s, o);
            d = {d[6:0], s};
        end
        clk_bit(~master_ack, s, o);
        oe_ack = o;
    endtask

    // Write <ptr><wq...>; checks ACKs and strobes, and updates the model.
    task automatic write_txn(input logic [7:0] p);
        logic        a;
        logic [15:0] exp_q[$];
        logic [15:0] got;
        strobe_q.delete();
        bus_start_idle();
        send_byte(8'h72, a); chk("wr_ack_addr", a, 1);
        send_byte(p, a);     chk("wr_ack_ptr", a, 1);
        m_ptr = int'(p);
        foreach (wq[i]) begin
            send_byte(wq[i], a); chk("wr_ack_data", a, 1);
            exp_q.push_back({8'(m_ptr), wq[i]});
            if (m_ptr < 16) m_regs[m_ptr] = wq[i];
            m_ptr = (m_ptr + 1) % 256;
        end
        bus_stop();
        chk("wr_busy_after_stop", busy, 0);
        chk("wr_strobe_count", strobe_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (strobe_q.size() > 0) begin
                got = strobe_q.pop_front();
                chk("wr_strobe_addr_data", got, exp_q[i]);
            end
        end
    endtask

    // Read n bytes (optionally setting the pointer first via repeated START).
    task automatic read_txn(input logic set_ptr, input logic [7:0] p, input int n, output logic [7:0] last);
        logic       a, o;
        logic [7:0] d;
        bus_start_idle();
        if (set_ptr) begin
            send_byte(8'h72, a); chk("rd_ack_waddr", a, 1);
            send_byte(p, a);     chk("rd_ack_ptr", a, 1);
            bus_restart();
            m_ptr = int'(p);
        end
        send_byte(8'h73, a); chk("rd_ack_raddr", a, 1);
        o = 1'b0;
        d = 8'h00;
        for (int i = 0; i < n; i++) begin
            recv_byte(i != n - 1, d, o);
            chk("rd_data", d, model_read(m_ptr));
            if (i != n - 1) m_ptr = (m_ptr + 1) % 256;
        end
        chk("rd_nack_slot_oe", o, 0);
        chk("rd_busy_after_nack", busy, 0);
        bus_stop();
        last = d;
    endtask

    task automatic chk_dbg(input logic [7:0] addr, input logic [7:0] exp);
        dbg_addr = addr;
        #1;
        chk("dbg_data", dbg_data, exp);
    endtask

    typedef struct {
        bit         rd;
        logic [7:0] ptr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic       a, s, o;
        logic [7:0] got;

        tbl[0] = '{1'b0, 8'h05, 8'hA5, 8'hA5};
        tbl[1] = '{1'b1, 8'h05, 8'h00, 8'hA5};
        tbl[2] = '{1'b0, 8'h00, 8'h3C, 8'h3C};
        tbl[3] = '{1'b1, 8'h00, 8'h00, 8'h3C};
        tbl[4] = '{1'b1, 8'h10, 8'h00, 8'hFF};
        tbl[5] = '{1'b0, 8'h0F, 8'h7E, 8'h7E};
        tbl[6] = '{1'b1, 8'h0F, 8'h00, 8'h7E};
        tbl[7] = '{1'b1, 8'h01, 8'h00, 8'h00};
        tbl[8] = '{1'b0, 8'hFF, 8'h99, 8'hFF};
        tbl[9] = '{1'b1, 8'hFF, 8'h00, 8'hFF};

        dbg_addr = 8'h00;
        oe_seen  = 1'b0;
        model_reset();

        // Reset state
        cyc(3);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_strobe", wr_strobe, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk_dbg(8'h00, 8'h00);
        reset = 1'b1;
        cyc(5);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rd) begin
                read_txn(1'b1, tbl[i].ptr, 1, got);
                chk("tbl_read", got, tbl[i].exp);
            end else begin
                wq.delete();
                wq.push_back(tbl[i].data);
                write_txn(tbl[i].ptr);
                chk_dbg(tbl[i].ptr, tbl[i].exp);
            end
        end

        // Burst write across the top of the register file
        wq.delete();
        wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33);
        write_txn(8'h0E);
        chk_dbg(8'h0E, 8'h11);
        chk_dbg(8'h0F, 8'h22);
        chk_dbg(8'h10, 8'hFF);
        read_txn(1'b1, 8'h10, 1, got);
        chk("burst_read_oob", got, 8'hFF);

        // STOP after 4 bits of a data byte
        strobe_q.delete();
        bus_start_idle();
        send_byte(8'h72, a); chk("part_ack_addr", a, 1);
        send_byte(8'h02, a); chk("part_ack_ptr", a, 1);
        m_ptr = 2;
        clk_bit(1'b1, s, o); clk_bit(1'b0, s, o);
        clk_bit(1'b1, s, o); clk_bit(1'b1, s, o);
        bus_stop();
        chk("part_no_strobe", strobe_q.size(), 0);
        chk("part_busy", busy, 0);
        chk_dbg(8'h02, 8'h00);
        wq.delete();
        wq.push_back(8'h44);
        write_txn(8'h02);
        chk_dbg(8'h02, 8'h44);

        // Address mismatch
        strobe_q.delete();
        oe_seen = 1'b0;
        bus_start_idle();
        send_byte(8'h74, a); chk("mis_nack_addr", a, 0);
        send_byte(8'h05, a); chk("mis_nack_b1", a, 0);
        send_byte(8'h5A, a); chk("mis_nack_b2", a, 0);
        bus_stop();
        chk("mis_oe_never", oe_seen, 0);
        chk("mis_no_strobe", strobe_q.size(), 0);
        chk("mis_busy", busy, 0);
        chk_dbg(8'h05, 8'hA5);

        // Reset while the target drives a 0 bit in a read
        wq.delete();
        wq.push_back(8'h5A);
        write_txn(8'h03);
        bus_start_idle();
        send_byte(8'h72, a); chk("rr_ack_waddr", a, 1);
        send_byte(8'h03, a); chk("rr_ack_ptr", a, 1);
        bus_restart();
        send_byte(8'h73, a); chk("rr_ack_raddr", a, 1);
        chk("rr_drive_zero", sda_oe, 1);
        #200;
        reset = 1'b0;
        #1;
        chk("rr_oe_released", sda_oe, 0);
        chk("rr_busy", busy, 0);
        scl  = 1'b1;
        msda = 1'b1;
        cyc(3);
        reset = 1'b1;
        cyc(5);
        model_reset();
        for (int i = 0; i < 16; i++) chk_dbg(8'(i), 8'h00);

        // Random traffic against the model
        for (int t = 0; t < 24; t++) begin
            int         kind, n;
            logic [7:0] p;
            kind = int'($urandom_range(0, 2));
            n    = int'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) p = 8'(8'hFE + 8'($urandom_range(0, 1)));
            else p = 8'($urandom_range(0, 19));
            if (kind == 0) begin
                wq.delete();
                for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
                write_txn(p);
            end else begin
                read_txn(kind == 1, p, n, got);
            end
        end
        for (int i = 0; i < 18; i++) chk_dbg(8'(i), model_read(i));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- I2C target (responder) with a small byte-addressed register file.
- Answers the same write and register-read transactions that the adv7513_init / adv7513_reg_read initiators issue.
- Used as an ADV7513 stand-in on the I2C bus in simulation, and as a camera-side target on camGPIO in hardware bring-up.
- Runs entirely in the clk_1us domain and oversamples SCL/SDA; no SCL clock domain exists.

Parameters:
- DEV_ADDR, 7'h39, 7-bit target address (0x72 write / 0x73 read on the wire).
- REG_ADDR_BITS, 4, implemented registers = 2**REG_ADDR_BITS (16).
- REG_INIT, 8'h00, reset value of every register.

Ports:
- clk_1us  input  1  sampling clock, 1 MHz.
- reset  input  1  asynchronous, active-low.
- scl_in  input  1  SCL pad value.
- sda_in  input  1  SDA pad value.
- sda_oe  output  1  1 = pull SDA low (open-drain). Top level drives the pad low when set and Z otherwise.
- busy  output  1  high from address-matched ACK until STOP, START, or NACK.
- wr_strobe  output  1  one-cycle pulse per register write.
- wr_addr  output  8  register pointer of the write; valid with wr_strobe.
- wr_data  output  8  data byte of the write; valid with wr_strobe.
- dbg_addr  input  8  side-band read address (bench/7-seg).
- dbg_data  output  8  combinational read of reg[dbg_addr]; 8'hFF if out of range.

Behaviour:
- Reset is async, active-low. On assertion:
  - sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0.
  - Register pointer = 0; all registers = REG_INIT; state = IDLE.
  - Reset mid-transfer releases SDA immediately.
- Input synchronisation: scl_in and sda_in each pass through 2 flops, plus one history flop for edge detection. Bus events are therefore seen 2-3 cycles late.
- The initiator must keep SCL low >= 5 us and high >= 4 us; the 600-divider from 50 MHz satisfies this.
- Bus event detection (synchronised signals):
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - START and STOP are checked in every state and take priority over data sampling in the same cycle.
- SDA timing: bits are sampled on the synchronised SCL rising edge. sda_oe changes only on the synchronised SCL falling edge, except for reset or STOP/START, which force sda_oe=0.
- Bit counter is 3 bits, MSB first, and is cleared on START and after each ACK slot.
- States:
  - IDLE: ignore the bus; START -> ADDR.
  - ADDR: shift 8 bits.
    - Address match -> ACK_ADDR.
    - Mismatch -> IDLE; sda_oe stays 0.
  - ACK_ADDR: drive sda_oe=1 for one SCL period; busy=1. Then:
    - R/W=0 -> PTR.
    - R/W=1 -> load shift register with reg[ptr], then RD_BYTE.
  - PTR: shift 8 bits into the pointer, then ACK_PTR.
  - ACK_PTR: ACK; -> WR_BYTE.
  - WR_BYTE: shift 8 bits, then ACK_WR, and in that cycle:
    - Pulse wr_strobe with wr_addr=ptr and wr_data=byte.
    - Write the register if ptr < 2**REG_ADDR_BITS; out-of-range writes are dropped but still ACKed.
    - ptr = ptr+1, wrapping 8'hFF -> 8'h00.
  - ACK_WR: ACK; -> WR_BYTE.
  - RD_BYTE: set sda_oe = ~bit on each SCL falling edge, MSB first. After 8 bits -> RD_ACK with sda_oe=0.
  - RD_ACK: sample initiator ACK on SCL rise.
    - ACK (SDA=0): ptr+1, load next byte, -> RD_BYTE.
    - NACK: busy=0, -> IDLE.
  - Out-of-range reads return 8'hFF.
- Repeated START in any state: -> ADDR, sda_oe=0. The pointer is retained, which gives the write-pointer / restart / read sequence used by adv7513_reg_read.
- STOP in any state: -> IDLE, busy=0.
  - A partial byte is discarded and no wr_strobe is issued.
  - The pointer is retained.
- No clock stretching: SCL is never driven.

Decomposition:
- Package i2c_pkg holds:
  - State encoding localparams (IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WR_BYTE, ACK_WR, RD_BYTE, RD_ACK).
  - ADV7513_I2C_ADDR = 7'h39.
  - I2C_ACK = 1'b0.
- Sub-module i2c_sync_edge: 2-flop synchroniser plus rise/fall pulse outputs. Instantiated once for SCL and once for SDA.

Test Plan:
- Write test: initiator at 83 kHz writes 0x72, 0x05, 0xA5, then STOP.
  - Required: three ACKs.
  - One wr_strobe with wr_addr=0x05, wr_data=0xA5.
  - dbg_addr=0x05 gives dbg_data=0xA5.
- Read test: write pointer 0x05, repeated START, 0x73, read one byte, NACK, STOP.
  - Required: byte on SDA = 0xA5.
  - busy drops after the NACK.
  - sda_oe stays 0 during the NACK slot.
- Address mismatch: 0x74 (7'h3A) then data bytes.
  - Required: no ACK; sda_oe=0 throughout; no wr_strobe.
- Burst write: pointer 0x0E, data 0x11, 0x22, 0x33.
  - Required: reg[0x0E]=0x11, reg[0x0F]=0x22.
  - Third strobe has wr_addr=0x10, is dropped, and is still ACKed.
  - Read at 0x10 returns 0xFF.
- STOP after 4 bits of a data byte.
  - Required: no wr_strobe; state IDLE; the next transaction works normally.
- Reset asserted while driving a 0 bit in RD_BYTE.
  - Required: sda_oe=0 within the same cycle.
  - All registers read REG_INIT afterwards.
